// File: rtl/ram_port_pkg.sv
// Shared types and sizing for the two-requester RAM port arbiter.
// Line/beat geometry, sequencer state encoding and the line-to-beat select helper.
package ram_port_pkg;

  localparam int unsigned RAM_ADDR_SIZE   = 13;
  localparam int unsigned RAM_WORD_SIZE   = 16;
  localparam int unsigned CACHE_STR_WIDTH = 64;
  localparam int unsigned BEATS           = CACHE_STR_WIDTH / RAM_WORD_SIZE;
  localparam int unsigned CNT_W           = $clog2(BEATS);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWbeat,
    StWack,
    StRbeat,
    StDone
  } state_e;

  function automatic logic [RAM_WORD_SIZE-1:0] line_beat(
    input logic [CACHE_STR_WIDTH-1:0] line,
    input logic [CNT_W-1:0]           idx
  );
    return line[RAM_WORD_SIZE*idx +: RAM_WORD_SIZE];
  endfunction

endpackage

// File: rtl/ram_burst_seq.sv
// Burst sequencer: issues one address strobe, then streams write beats or collects
// read beats into a line, and pulses done for one cycle when the burst finishes.
module ram_burst_seq
  import ram_port_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cmd_rnw,
  input  logic [RAM_ADDR_SIZE-1:0]   cmd_addr,
  input  logic [CACHE_STR_WIDTH-1:0] cmd_wdata,
  input  logic [CACHE_STR_WIDTH-1:0] line_wdata,
  input  logic [RAM_WORD_SIZE-1:0]   ram_rdata,
  input  logic                       ram_ack,
  output logic                       idle,
  output logic                       done,
  output logic [CACHE_STR_WIDTH-1:0] line,
  output logic [RAM_ADDR_SIZE-1:0]   ram_addr,
  output logic [RAM_WORD_SIZE-1:0]   ram_wdata,
  output logic                       ram_avalid,
  output logic                       ram_rnw
);

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
  assign idle    = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done       <= 1'b0;
      line       <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_avalid <= 1'b0;
      ram_rnw    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q    <= StAddr;
            cnt_q      <= '0;
            ram_avalid <= 1'b1;
            ram_addr   <= cmd_addr;
            ram_rnw    <= cmd_rnw;
            // Beat 0 comes straight from the request mux so it is on the bus with the strobe.
            if (!cmd_rnw) ram_wdata <= line_beat(cmd_wdata, '0);
          end
        end
        StAddr: begin
          ram_avalid <= 1'b0;
          if (ram_rnw) begin
            state_q <= StRbeat;
          end else begin
            state_q   <= StWbeat;
            cnt_q     <= cnt_inc;
            ram_wdata <= line_beat(line_wdata, cnt_inc);
          end
        end
        StWbeat: begin
          if (cnt_q == LastBeat) begin
            state_q <= StWack;
          end else begin
            cnt_q     <= cnt_inc;
            ram_wdata <= line_beat(line_wdata, cnt_inc);
          end
        end
        StWack: begin
          if (ram_ack) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StRbeat: begin
          if (ram_ack) begin
            line[RAM_WORD_SIZE*cnt_q +: RAM_WORD_SIZE] <= ram_rdata;
            cnt_q <= cnt_inc;
            if (cnt_q == LastBeat) begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester cache-line arbiter for a single 16-bit RAM port.
// Define ARB_ROUND_ROBIN_EN for alternating grant on contention; default is req0 priority.
module ram_port_arbiter
  import ram_port_pkg::*;
(
  input  logic                       ram_clk,
  input  logic                       ram_rst,
  input  logic                       req0_valid,
  input  logic                       req0_rnw,
  input  logic [RAM_ADDR_SIZE-1:0]   req0_addr,
  input  logic [CACHE_STR_WIDTH-1:0] req0_wdata,
  output logic [CACHE_STR_WIDTH-1:0] req0_rdata,
  output logic                       req0_done,
  input  logic                       req1_valid,
  input  logic                       req1_rnw,
  input  logic [RAM_ADDR_SIZE-1:0]   req1_addr,
  input  logic [CACHE_STR_WIDTH-1:0] req1_wdata,
  output logic [CACHE_STR_WIDTH-1:0] req1_rdata,
  output logic                       req1_done,
  output logic [RAM_ADDR_SIZE-1:0]   ram_addr,
  output logic [RAM_WORD_SIZE-1:0]   ram_wdata,
  output logic                       ram_avalid,
  output logic                       ram_rnw,
  input  logic [RAM_WORD_SIZE-1:0]   ram_rdata,
  input  logic                       ram_ack
);

  logic                       seq_idle;
  logic                       seq_done;
  logic [CACHE_STR_WIDTH-1:0] seq_line;
  logic                       grant;
  logic                       sel;
  logic                       cmd_rnw;
  logic [RAM_ADDR_SIZE-1:0]   cmd_addr;
  logic [CACHE_STR_WIDTH-1:0] cmd_wdata;
  logic                       grant_q;
  logic                       rnw_q;
  logic [CACHE_STR_WIDTH-1:0] wdata_q;
  logic [CACHE_STR_WIDTH-1:0] rdata0_q;
  logic [CACHE_STR_WIDTH-1:0] rdata1_q;
  logic                       fin0;
  logic                       fin1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  assign sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) last_grant_q <= 1'b1;
    else if (grant) last_grant_q <= sel;
  end
`else
  assign sel = ~req0_valid;
`endif

  assign grant     = seq_idle & (req0_valid | req1_valid);
  assign cmd_rnw   = sel ? req1_rnw : req0_rnw;
  assign cmd_addr  = sel ? req1_addr : req0_addr;
  assign cmd_wdata = sel ? req1_wdata : req0_wdata;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      grant_q  <= 1'b0;
      rnw_q    <= 1'b1;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant) begin
        grant_q <= sel;
        rnw_q   <= cmd_rnw;
        wdata_q <= cmd_wdata;
      end
      if (fin0) rdata0_q <= seq_line;
      if (fin1) rdata1_q <= seq_line;
    end
  end

  // The finished line is forwarded during the done cycle, then held in the per-port register.
  assign fin0       = seq_done & ~grant_q & rnw_q;
  assign fin1       = seq_done & grant_q & rnw_q;
  assign req0_done  = seq_done & ~grant_q;
  assign req1_done  = seq_done & grant_q;
  assign req0_rdata = fin0 ? seq_line : rdata0_q;
  assign req1_rdata = fin1 ? seq_line : rdata1_q;

  ram_burst_seq u_seq (
    .clk        (ram_clk),
    .rst        (ram_rst),
    .start      (grant),
    .cmd_rnw    (cmd_rnw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .line_wdata (wdata_q),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack),
    .idle       (seq_idle),
    .done       (seq_done),
    .line       (seq_line),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_avalid (ram_avalid),
    .ram_rnw    (ram_rnw)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: RAM responder model plus expected-completion queue.
module tb_ram_port_arbiter;

  logic        ram_clk;
  logic        ram_rst;
  logic        req0_valid, req0_rnw, req1_valid, req1_rnw;
  logic [12:0] req0_addr, req1_addr, ram_addr;
  logic [63:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic        req0_done, req1_done;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_avalid, ram_rnw, ram_ack;

  typedef struct {
    bit          id;
    bit          rnw;
    logic [12:0] addr;
    logic [63:0] line;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem[logic [12:0]];
  int unsigned ack_pat[$];
  int          wr_delay;
  int          checks;
  int          failures;
  int          done_cnt;

  ram_port_arbiter dut (
    .ram_clk    (ram_clk),
    .ram_rst    (ram_rst),
    .req0_valid (req0_valid),
    .req0_rnw   (req0_rnw),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_rdata (req0_rdata),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_rnw   (req1_rnw),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_rdata (req1_rdata),
    .req1_done  (req1_done),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_avalid (ram_avalid),
    .ram_rnw    (ram_rnw),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  initial begin
    ram_clk = 1'b0;
    forever #5 ram_clk = ~ram_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_line(input logic [12:0] a);
    if (mem.exists(a)) return mem[a];
    return {3'b100, a, 3'b011, a, 3'b010, a, 3'b001, a};
  endfunction

  // Completion monitor: every done pulse must match the oldest expected transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge ram_clk);
      if (req0_done || req1_done) begin
        done_cnt++;
        check("done_onehot", {63'd0, req0_done & req1_done}, 64'd0);
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_id", {63'd0, req1_done}, {63'd0, e.id});
          if (e.rnw) check("rdata", e.id ? req1_rdata : req0_rdata, e.line);
        end
      end
    end
  end

  // RAM responder: reacts to the address strobe, serves reads from the model, absorbs writes.
  initial begin
    exp_t        e;
    logic [63:0] line;
    logic [15:0] wd[4];
    int          nb;
    ram_ack   = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge ram_clk);
      #1;
      if (ram_avalid && !ram_rst) begin
        if (exp_q.size() == 0) begin
          check("burst_unexpected", 64'd1, 64'd0);
          e.rnw = ram_rnw;
          e.addr = ram_addr;
          e.line = '0;
        end else begin
          e = exp_q[0];
          check("burst_addr", {51'd0, ram_addr}, {51'd0, e.addr});
          check("burst_rnw", {63'd0, ram_rnw}, {63'd0, e.rnw});
        end
        if (ram_rnw) begin
          line = model_line(ram_addr);
          nb = 0;
          for (int i = 0; i < ack_pat.size() && nb < 4; i++) begin
            @(posedge ram_clk);
            #1;
            ram_ack = ack_pat[i][0];
            if (ack_pat[i] != 0) begin
              ram_rdata = line[16*nb +: 16];
              nb++;
            end
          end
          @(posedge ram_clk);
          #1;
          ram_ack = 1'b0;
        end else begin
          wd[0] = ram_wdata;
          for (int k = 1; k < 4; k++) begin
            @(posedge ram_clk);
            #1;
            if (k == 1) check("avalid_one_cycle", {63'd0, ram_avalid}, 64'd0);
            wd[k] = ram_wdata;
          end
          for (int k = 0; k < 4; k++) check($sformatf("wbeat%0d", k), {48'd0, wd[k]},
                                             {48'd0, e.line[16*k +: 16]});
          repeat (wr_delay) @(posedge ram_clk);
          @(posedge ram_clk);
          #1;
          check("wdata_hold", {48'd0, ram_wdata}, {48'd0, e.line[63:48]});
          ram_ack = 1'b1;
          mem[e.addr] = {wd[3], wd[2], wd[1], wd[0]};
          @(posedge ram_clk);
          #1;
          ram_ack = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_avalid", {63'd0, ram_avalid}, 64'd0);
    check("rst_rnw", {63'd0, ram_rnw}, 64'd1);
    check("rst_addr", {51'd0, ram_addr}, 64'd0);
    check("rst_wdata", {48'd0, ram_wdata}, 64'd0);
    check("rst_done0", {63'd0, req0_done}, 64'd0);
    check("rst_done1", {63'd0, req1_done}, 64'd0);
    check("rst_rdata0", req0_rdata, 64'd0);
    check("rst_rdata1", req1_rdata, 64'd0);
  endtask

  task automatic single(input bit id, input bit rnw, input logic [12:0] addr,
                        input logic [63:0] wline, input int exp_lat);
    exp_t e;
    int   n;
    bit   got;
    e.id   = id;
    e.rnw  = rnw;
    e.addr = addr;
    e.line = rnw ? model_line(addr) : wline;
    exp_q.push_back(e);
    @(posedge ram_clk);
    #1;
    if (id) begin
      req1_valid = 1'b1; req1_rnw = rnw; req1_addr = addr; req1_wdata = wline;
    end else begin
      req0_valid = 1'b1; req0_rnw = rnw; req0_addr = addr; req0_wdata = wline;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge ram_clk);
      n++;
      got = id ? req1_done : req0_done;
      // Request already latched: scramble the inputs to prove they are ignored.
      if (n == 2) begin
        req0_wdata = ~req0_wdata; req1_wdata = ~req1_wdata;
        req0_addr  = ~req0_addr;  req1_addr  = ~req1_addr;
      end
    end
    check("latency", n, exp_lat);
    if (!got) exp_q.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge ram_clk);
    if (rnw) check("rdata_hold", id ? req1_rdata : req0_rdata, e.line);
  endtask

  task automatic dual_read(input logic [12:0] a0, input logic [12:0] a1, input bit first);
    exp_t e0, e1;
    bit   got0, got1;
    int   first_id;
    e0.id = 1'b0; e0.rnw = 1'b1; e0.addr = a0; e0.line = model_line(a0);
    e1.id = 1'b1; e1.rnw = 1'b1; e1.addr = a1; e1.line = model_line(a1);
    if (first) begin
      exp_q.push_back(e1); exp_q.push_back(e0);
    end else begin
      exp_q.push_back(e0); exp_q.push_back(e1);
    end
    @(posedge ram_clk);
    #1;
    req0_valid = 1'b1; req0_rnw = 1'b1; req0_addr = a0;
    req1_valid = 1'b1; req1_rnw = 1'b1; req1_addr = a1;
    got0 = 1'b0;
    got1 = 1'b0;
    first_id = -1;
    for (int n = 0; n < 100 && !(got0 && got1); n++) begin
      @(negedge ram_clk);
      if (req0_done) begin
        got0 = 1'b1; req0_valid = 1'b0;
        if (first_id < 0) first_id = 0;
      end
      if (req1_done) begin
        got1 = 1'b1; req1_valid = 1'b0;
        if (first_id < 0) first_id = 1;
      end
    end
    check("dual_both_done", {63'd0, got0 & got1}, 64'd1);
    check("dual_order", first_id, first);
    if (!(got0 && got1)) exp_q.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge ram_clk);
  endtask

  initial begin
    int  saved;
    bit  rr_first;
    checks = 0; failures = 0; done_cnt = 0;
    ram_rst = 1'b1;
    req0_valid = 1'b0; req0_rnw = 1'b1; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rnw = 1'b1; req1_addr = '0; req1_wdata = '0;
    ack_pat = '{1, 1, 1, 1};
    wr_delay = 0;
    mem[13'h0101] = 64'h3000_2000_1000_080f;
    repeat (3) @(posedge ram_clk);
    #1;
    ram_rst = 1'b0;
    @(negedge ram_clk);
    check_reset_outputs();

    single(1'b0, 1'b1, 13'h0101, 64'd0, 7);
    wr_delay = 5;
    single(1'b1, 1'b0, 13'h0303, 64'h3000_2000_1000_181f, 12);
    wr_delay = 0;
    single(1'b0, 1'b0, 13'h0404, 64'hdead_beef_0123_4567, 7);
    single(1'b1, 1'b1, 13'h0303, 64'd0, 7);

    ack_pat = '{1, 0, 0, 1, 1, 0, 1};
    single(1'b1, 1'b1, 13'h0404, 64'd0, 10);
    ack_pat = '{1, 1, 1, 1};

    // Spurious ack while idle must not start or complete anything.
    saved = done_cnt;
    @(posedge ram_clk);
    #1;
    ram_ack = 1'b1;
    repeat (3) @(posedge ram_clk);
    #1;
    ram_ack = 1'b0;
    check("spurious_no_done", done_cnt, saved);
    wr_delay = 3;
    single(1'b1, 1'b0, 13'h0606, 64'h0123_4567_89ab_cdef, 10);
    wr_delay = 0;

    // Reset during a read after two beats: burst abandoned, no done.
    ack_pat = '{1, 1, 0, 0, 0, 0};
    begin
      exp_t e;
      e.id = 1'b0; e.rnw = 1'b1; e.addr = 13'h0555; e.line = model_line(13'h0555);
      exp_q.push_back(e);
    end
    saved = done_cnt;
    @(posedge ram_clk);
    #1;
    req0_valid = 1'b1; req0_rnw = 1'b1; req0_addr = 13'h0555;
    repeat (4) @(posedge ram_clk);
    #1;
    ram_rst = 1'b1;
    req0_valid = 1'b0;
    @(negedge ram_clk);
    @(negedge ram_clk);
    check_reset_outputs();
    @(posedge ram_clk);
    #1;
    ram_rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge ram_clk);
    check("rst_no_done", done_cnt, saved);
    ack_pat = '{1, 1, 1, 1};
    single(1'b0, 1'b1, 13'h0101, 64'd0, 7);

`ifdef ARB_ROUND_ROBIN_EN
    rr_first = 1'b1;
`else
    rr_first = 1'b0;
`endif
    dual_read(13'h0303, 13'h0404, rr_first);
    dual_read(13'h0404, 13'h0606, rr_first);

    repeat (3) @(posedge ram_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 16-bit RAM port between two cache-line requesters (e.g. instruction and data cache controllers).
- Moves whole 64-bit lines as 4-beat bursts, beat 0 = bits [15:0], low word first.
- Sits between the cache controllers and the RAM model, on the RAM clock domain.
- Arbitrates, latches the winning request, sequences the beats, and returns a one-cycle done pulse to the winner.

Parameters:
RAM_ADDR_SIZE, 13, line address width (tag+index)
RAM_WORD_SIZE, 16, RAM data beat width
CACHE_STR_WIDTH, 64, cache line width; beats = CACHE_STR_WIDTH/RAM_WORD_SIZE (4)

Ports:
ram_clk  in  1  single clock
ram_rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 request; level, held until req0_done
req0_rnw  in  1  1=line read, 0=line write
req0_addr  in  RAM_ADDR_SIZE  line address
req0_wdata  in  CACHE_STR_WIDTH  write line
req0_rdata  out  CACHE_STR_WIDTH  read line; valid when req0_done=1
req0_done  out  1  one-cycle completion pulse
req1_valid, req1_rnw, req1_addr, req1_wdata, req1_rdata, req1_done  (same as requester 0)
ram_addr  out  RAM_ADDR_SIZE  burst address
ram_wdata  out  RAM_WORD_SIZE  write beat
ram_avalid  out  1  address strobe, one cycle per burst
ram_rnw  out  1  burst direction
ram_rdata  in  RAM_WORD_SIZE  read beat
ram_ack  in  1  read: beat valid; write: burst complete

Behaviour:
- Reset values: ram_avalid=0, ram_rnw=1, ram_addr=0, ram_wdata=0, reqN_done=0, reqN_rdata=0.
- State register: IDLE, ADDR, WBEAT, WACK, RBEAT, DONE.
- Reset forces IDLE and clears beat counter and grant; any burst in flight is abandoned without a done pulse.
- IDLE:
  - If any reqN_valid, grant one requester and latch its rnw, addr and wdata (unlatched inputs are ignored afterwards). Next state is ADDR.
  - Grant is fixed priority, req0 wins, unless ARB_ROUND_ROBIN_EN is defined.
- ADDR (1 cycle):
  - Drive ram_avalid=1, ram_addr and ram_rnw.
  - On a write, ram_wdata carries beat 0 in the same cycle.
  - Next state is WBEAT on a write, RBEAT on a read.
- WBEAT: beats 1..3 are driven on the 3 consecutive cycles after ADDR, then WACK. ram_wdata is held at beat 3 afterwards.
- WACK: waits indefinitely for ram_ack=1, then DONE.
- RBEAT:
  - Each cycle with ram_ack=1 captures ram_rdata into beat[cnt], then cnt++.
  - Gaps between acks are allowed.
  - When the 4th beat is captured, go to DONE.
- ram_ack outside WACK/RBEAT is ignored.
- DONE (1 cycle):
  - Assert reqG_done=1 for the granted requester only.
  - On a read, reqG_rdata holds the assembled line from this cycle until its next read completes.
  - Next state is IDLE. A new grant is possible in the cycle after DONE; there are no back-to-back grants in the DONE cycle.
- Minimum latency, req_valid rise to done:
  - Write: 1 (IDLE) + 1 (ADDR) + 3 (WBEAT) + 1 (WACK, ack already high) + 1 (DONE) = 7 cycles.
  - Read: 1 + 1 + 4 (RBEAT, continuous ack) + 1 = 7 cycles.
- Requester dropping valid mid-burst: the burst completes regardless and the done pulse is still issued.
- The requester must deassert valid in the cycle after done; otherwise it is re-granted.
- Beat counter is 2 bits, cleared on entry to ADDR; wrap from 3 to 0 is not used as a terminal condition.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset 1, so req0 wins first). When both requesters are valid in IDLE, the one not granted last wins. last_grant updates at grant.
- Undefined: strict priority, req0 always wins; no last_grant register exists.

Decomposition:
- Shared package ram_port_pkg holds:
  - the state enum (IDLE, ADDR, WBEAT, WACK, RBEAT, DONE);
  - BEATS = CACHE_STR_WIDTH/RAM_WORD_SIZE;
  - the beat counter width $clog2(BEATS).
- One natural sub-module, ram_burst_seq: the ADDR/WBEAT/WACK/RBEAT sequencer with line-to-beat mux and beat-to-line assembly.
- The top level holds only grant logic, the request latch and done/rdata steering.

Test Plan:
- req0 read of addr 13'h0101; RAM returns beats 080f, 1000, 2000, 3000 on 4 consecutive acks.
  -> req0_rdata=64'h300020001000080f with req0_done at cycle 7; req1_done stays 0.
- req1 write, addr 13'h0303, wdata 64'h300020001000181f; ack given 5 cycles after WBEAT ends.
  -> ram_wdata sequence 181f, 1000, 2000, 3000; ram_avalid exactly one cycle; req1_done one cycle after ack.
- req0 and req1 both valid at the same cycle, both reads.
  -> Without the macro: req0 is served first, then req1.
  -> With ARB_ROUND_ROBIN_EN: req0, then req1, then req0 again on a repeated double request.
- Read with gapped acks (ack, idle, idle, ack, ack, idle, ack).
  -> Line assembled in the correct beat order; done only after the 4th ack.
- ram_rst asserted during RBEAT after 2 beats.
  -> All outputs at reset values next cycle; no done pulse; a subsequent req0 read completes normally.
- Spurious ram_ack while IDLE, then a req1 write.
  -> Ignored; the write still waits for its own WACK ack.
